// File: rtl/mat_pkg.sv
// Shared sizing, FSM state type and element type for the matrix operand loader.
package mat_pkg;
  localparam int unsigned N  = 8;
  localparam int unsigned EW = 8;
  localparam int unsigned CW = $clog2(2 * N * N) + 1;

  typedef enum logic [1:0] {LOAD_A, LOAD_B, HOLD} ldr_state_t;

  typedef logic [EW-1:0] elem_t;
endpackage

// File: rtl/mat_operand_bank.sv
// N*N element register bank with a single indexed write port and a flat read bus.
module mat_operand_bank
  import mat_pkg::*;
#(
  parameter int unsigned N  = mat_pkg::N,
  parameter int unsigned EW = mat_pkg::EW
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [$clog2(N*N)-1:0]   wr_idx,
  input  logic [EW-1:0]            wr_data,
  output logic [N*N*EW-1:0]        flat
);

  logic [N*N-1:0][EW-1:0] mem_q, mem_d;

  always_comb begin
    mem_d = mem_q;
    if (wr_en) mem_d[wr_idx] = wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mem_q <= '0;
    else        mem_q <= mem_d;
  end

  assign flat = mem_q;

endmodule

// File: rtl/mat_operand_loader.sv
// Streams mat1 then mat2 (row-major) into two operand banks and hands them off.
// Define TRANSPOSE_B_EN to store mat2 transposed (columns of B contiguous).
module mat_operand_loader #(
  parameter int unsigned N  = mat_pkg::N,
  parameter int unsigned EW = mat_pkg::EW,
  parameter int unsigned CW = $clog2(2 * N * N) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [EW-1:0]     in_data,
  output logic              in_ready,
  output logic              mat_valid,
  input  logic              mat_ready,
  output logic [N*N*EW-1:0] mat1_flat,
  output logic [N*N*EW-1:0] mat2_flat,
  output logic [CW-1:0]     elem_count
);
  import mat_pkg::*;

  localparam int unsigned NN = N * N;
  localparam int unsigned IW = $clog2(NN);
  localparam logic [CW-1:0] NN_C   = CW'(NN);
  localparam logic [CW-1:0] LAST_A = CW'(NN - 1);
  localparam logic [CW-1:0] LAST_B = CW'(2 * NN - 1);
  localparam logic [CW-1:0] N_C    = CW'(N);

  ldr_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          in_ready_q, in_ready_d;

  logic          accept;
  logic          wr1, wr2;
  logic [CW-1:0] k2;
  logic [IW-1:0] idx1, idx2;

  // flush wins over every other event, including an accept in the same cycle
  always_comb begin
    accept  = in_valid & in_ready_q & ~flush;
    state_d = state_q;
    cnt_d   = cnt_q;
    if (flush) begin
      state_d = LOAD_A;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        LOAD_A: if (accept) begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == LAST_A) state_d = LOAD_B;
        end
        LOAD_B: if (accept) begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == LAST_B) state_d = HOLD;
        end
        HOLD: if (mat_ready) begin
          state_d = LOAD_A;
          cnt_d   = '0;
        end
        default: begin
          state_d = LOAD_A;
          cnt_d   = '0;
        end
      endcase
    end
    in_ready_d = (state_d != HOLD);
  end

  always_comb begin
    wr1  = accept & (cnt_q < NN_C);
    wr2  = accept & ~(cnt_q < NN_C);
    idx1 = IW'(cnt_q);
    k2   = cnt_q - NN_C;
`ifdef TRANSPOSE_B_EN
    idx2 = IW'((k2 % N_C) * N_C + k2 / N_C);
`else
    idx2 = IW'(k2);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= LOAD_A;
      cnt_q      <= '0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign mat_valid  = (state_q == HOLD);
  assign elem_count = cnt_q;

  mat_operand_bank #(.N(N), .EW(EW)) u_mat1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr1),
    .wr_idx  (idx1),
    .wr_data (in_data),
    .flat    (mat1_flat)
  );

  mat_operand_bank #(.N(N), .EW(EW)) u_mat2 (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr2),
    .wr_idx  (idx2),
    .wr_data (in_data),
    .flat    (mat2_flat)
  );

endmodule

// File: tb/tb_mat_operand_loader.sv
// Scoreboard bench for mat_operand_loader; honours TRANSPOSE_B_EN for mat2 layout.
module tb_mat_operand_loader;
  localparam int unsigned N  = 8;
  localparam int unsigned EW = 8;
  localparam int unsigned CW = 8;
  localparam int unsigned FW = N * N * EW;

  logic          clk = 1'b0;
  logic          rst_n, flush, in_valid, in_ready, mat_valid, mat_ready;
  logic [EW-1:0] in_data;
  logic [FW-1:0] mat1_flat, mat2_flat;
  logic [CW-1:0] elem_count;

  int unsigned n_cmp = 0;
  int unsigned n_fail = 0;
  int unsigned exp_cnt;
  logic [2*FW-1:0] sb_q[$];
  logic [FW-1:0]   e1, e2;

  mat_operand_loader #(.N(N), .EW(EW), .CW(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .mat_valid  (mat_valid),
    .mat_ready  (mat_ready),
    .mat1_flat  (mat1_flat),
    .mat2_flat  (mat2_flat),
    .elem_count (elem_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected bank contents: kind 0 -> element k = k, kind 1 -> all 0xA5
  task automatic build_exp(input int kind);
    int unsigned idx;
    for (int unsigned j = 0; j < N * N; j++) begin
`ifdef TRANSPOSE_B_EN
      idx = (j % N) * N + (j / N);
`else
      idx = j;
`endif
      e1[j*EW +: EW]   = (kind == 0) ? EW'(j) : 8'hA5;
      e2[idx*EW +: EW] = (kind == 0) ? EW'(j + N * N) : 8'hA5;
    end
  endtask

  // Monitor: every completed handshake is checked against the scoreboard
  always @(negedge clk) begin
    if (rst_n && mat_valid && mat_ready) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL handoff_unexpected: got handoff expected none");
      end else begin
        logic [2*FW-1:0] e;
        e = sb_q.pop_front();
        chk("mon_mat1_flat", mat1_flat, e[2*FW-1:FW]);
        chk("mon_mat2_flat", mat2_flat, e[FW-1:0]);
      end
    end
  end

  task automatic send(input logic [EW-1:0] d, input bit rnd);
    int unsigned tries = 0;
    bit done = 1'b0;
    bit will;
    while (!done) begin
      in_data  = d;
      in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      will     = in_valid && in_ready;
      @(posedge clk); #1;
      if (will) begin
        done = 1'b1;
        exp_cnt++;
      end
      if (rnd) chk("elem_count_beat", FW'(elem_count), FW'(exp_cnt));
      tries++;
      if (!done && tries > 100) begin
        n_cmp++;
        n_fail++;
        $display("FAIL send_timeout: got no accept expected accept within 100 cycles");
        done = 1'b1;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic load(input int kind, input bit rnd);
    exp_cnt = 0;
    for (int unsigned k = 0; k < 2 * N * N; k++) begin
      if (k == 2 * N * N - 1) begin
        chk("pre_last_valid", FW'(mat_valid), FW'(0));
        chk("pre_last_count", FW'(elem_count), FW'(127));
      end
      send((kind == 0) ? EW'(k) : 8'hA5, rnd);
    end
    chk("load_mat_valid", FW'(mat_valid), FW'(1));
    chk("load_in_ready", FW'(in_ready), FW'(0));
    chk("load_elem_count", FW'(elem_count), FW'(128));
  endtask

  task automatic handoff();
    mat_ready = 1'b1;
    @(posedge clk); #1;
    mat_ready = 1'b0;
    chk("post_hs_mat_valid", FW'(mat_valid), FW'(0));
    chk("post_hs_in_ready", FW'(in_ready), FW'(1));
    chk("post_hs_count", FW'(elem_count), FW'(0));
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; mat_ready = 1'b0;
    #12;
    chk("rst_in_ready", FW'(in_ready), FW'(0));
    chk("rst_mat_valid", FW'(mat_valid), FW'(0));
    chk("rst_elem_count", FW'(elem_count), FW'(0));
    chk("rst_mat1", mat1_flat, '0);
    chk("rst_mat2", mat2_flat, '0);
    @(negedge clk); rst_n = 1'b1;
    #1 chk("rel_in_ready_before_edge", FW'(in_ready), FW'(0));
    @(posedge clk); #1;
    chk("rel_in_ready_after_edge", FW'(in_ready), FW'(1));

    // Scenario 1: sequential stream k = 0..127
    build_exp(0);
    sb_q.push_back({e1, e2});
    load(0, 1'b0);
    chk("A00", FW'(mat1_flat[0 +: 8]), FW'(0));
    chk("A77", FW'(mat1_flat[63*8 +: 8]), FW'(63));
    chk("B00", FW'(mat2_flat[0 +: 8]), FW'(64));
`ifdef TRANSPOSE_B_EN
    chk("B07_t", FW'(mat2_flat[56*8 +: 8]), FW'(71));
    chk("mat2_idx1_t", FW'(mat2_flat[1*8 +: 8]), FW'(72));
    chk("mat2_idx8_t", FW'(mat2_flat[8*8 +: 8]), FW'(65));
`else
    chk("B07", FW'(mat2_flat[7*8 +: 8]), FW'(71));
    chk("mat2_idx1", FW'(mat2_flat[1*8 +: 8]), FW'(65));
    chk("mat2_idx8", FW'(mat2_flat[8*8 +: 8]), FW'(72));
`endif

    // Scenario 2: backpressure in HOLD with in_valid active
    for (int unsigned c = 0; c < 20; c++) begin
      in_valid = 1'b1;
      in_data  = 8'hFF;
      @(posedge clk); #1;
      chk("hold_in_ready", FW'(in_ready), FW'(0));
      chk("hold_mat_valid", FW'(mat_valid), FW'(1));
      chk("hold_count", FW'(elem_count), FW'(128));
      chk("hold_mat1", mat1_flat, e1);
      chk("hold_mat2", mat2_flat, e2);
    end
    in_valid = 1'b0;
    handoff();

    // Scenario 4: flush after 70 accepts, then reload with 0xA5
    exp_cnt = 0;
    for (int unsigned k = 0; k < 70; k++) send(8'h11, 1'b0);
    chk("pre_flush_count", FW'(elem_count), FW'(70));
    flush = 1'b1; in_valid = 1'b1; in_data = 8'h22;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_count", FW'(elem_count), FW'(0));
    chk("flush_in_ready", FW'(in_ready), FW'(1));
    chk("flush_mat_valid", FW'(mat_valid), FW'(0));
    chk("flush_mat1_kept", FW'(mat1_flat[5*8 +: 8]), FW'(8'h11));
`ifdef TRANSPOSE_B_EN
    chk("flush_discard_t", FW'(mat2_flat[48*8 +: 8]), FW'(70));
`else
    chk("flush_discard", FW'(mat2_flat[6*8 +: 8]), FW'(70));
`endif
    build_exp(1);
    sb_q.push_back({e1, e2});
    load(1, 1'b0);
    handoff();

    // Scenario 3: random in_valid gaps, same contents as scenario 1
    build_exp(0);
    sb_q.push_back({e1, e2});
    load(0, 1'b1);
    handoff();

    // Scenario 5: asynchronous reset while holding
    load(0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_mat_valid", FW'(mat_valid), FW'(0));
    chk("arst_in_ready", FW'(in_ready), FW'(0));
    chk("arst_count", FW'(elem_count), FW'(0));
    chk("arst_mat1", mat1_flat, '0);
    chk("arst_mat2", mat2_flat, '0);
    @(negedge clk); rst_n = 1'b1;
    #1 chk("arst_rel_before_edge", FW'(in_ready), FW'(0));
    @(posedge clk); #1;
    chk("arst_rel_after_edge", FW'(in_ready), FW'(1));

    chk("sb_drained", FW'(sb_q.size()), FW'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
